// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, access
// sizes, byte-enable patterns and the alignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Size 11 is treated as misaligned so it is rejected without a bus cycle.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return addr_lo[0];
      SIZE_W:  return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store byte enables and data replication, plus load lane
// selection with sign or zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_raw_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane   = load_raw_i[{addr_lo_i, 3'b000} +: 8];
    half_lane   = addr_lo_i[1] ? load_raw_i[31:16] : load_raw_i[15:0];
    be_o        = BE_NONE;
    wdata_o     = store_data_i;
    load_data_o = load_raw_i;
    case (size_i)
      SIZE_B: begin
        be_o        = BE_BYTE0 << addr_lo_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = {{24{byte_lane[7] & ~unsigned_i}}, byte_lane};
      end
      SIZE_H: begin
        be_o        = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_o     = {2{store_data_i[15:0]}};
        load_data_o = {{16{half_lane[15] & ~unsigned_i}}, half_lane};
      end
      SIZE_W: begin
        be_o = BE_WORD;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one req/ack data-bus transaction per memory instruction,
// stalling the core until completion; misaligned accesses never reach the bus.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rD2_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic [31:0] load_data_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_be_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i
);

  state_e      state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        done_q, done_d;
  logic        misalign_q, misalign_d;
  logic [31:0] load_data_q, load_data_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  logic        in_idle;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  // One aligner serves both directions: in IDLE it sees the incoming
  // instruction (store payload), afterwards the latched fields (load lanes).
  assign in_idle = (state_q == ST_IDLE);

  lsu_align u_align (
    .size_i       (in_idle ? mem_size_i : size_q),
    .unsigned_i   (in_idle ? mem_unsigned_i : uns_q),
    .addr_lo_i    (in_idle ? alu_result_i[1:0] : addr_lo_q),
    .store_data_i (rD2_i),
    .load_raw_i   (dbus_rdata_i),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load)
  );

  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    size_d      = size_q;
    uns_d       = uns_q;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    load_data_d = load_data_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    stall_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_o = mem_req_i;
        if (mem_req_i) begin
          addr_lo_d = alu_result_i[1:0];
          size_d    = mem_size_i;
          uns_d     = mem_unsigned_i;
          if (is_misaligned(mem_size_i, alu_result_i[1:0])) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d = ST_BUSY;
            req_d   = 1'b1;
            we_d    = mem_we_i;
            addr_d  = {alu_result_i[31:2], 2'b00};
            wdata_d = al_wdata;
            be_d    = al_be;
          end
        end
      end
      ST_BUSY: begin
        stall_o = 1'b1;
        if (dbus_ack_i) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) load_data_d = al_load;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_lo_q   <= 2'b00;
      size_q      <= SIZE_B;
      uns_q       <= 1'b0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      load_data_q <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= BE_NONE;
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      load_data_q <= load_data_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
    end
  end

  assign done_o       = done_q;
  assign misalign_o   = misalign_q;
  assign load_data_o  = load_data_q;
  assign dbus_req_o   = req_q;
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_wdata_o = wdata_q;
  assign dbus_be_o    = be_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed memory instructions against a transaction-level
// model, per-cycle comparison, plus literal expectations for key cases.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_uns = 1'b0;
  logic [31:0] alu = '0;
  logic [31:0] rd2 = '0;
  logic        ack = 1'b0;
  logic [31:0] rdata = '0;

  logic        stall_o, done_o, misalign_o, dbus_req_o, dbus_we_o;
  logic [31:0] load_data_o, dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_be_o;

  lsu dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mem_req_i      (mem_req),
    .mem_we_i       (mem_we),
    .mem_size_i     (mem_size),
    .mem_unsigned_i (mem_uns),
    .alu_result_i   (alu),
    .rD2_i          (rd2),
    .stall_o        (stall_o),
    .done_o         (done_o),
    .misalign_o     (misalign_o),
    .load_data_o    (load_data_o),
    .dbus_req_o     (dbus_req_o),
    .dbus_we_o      (dbus_we_o),
    .dbus_addr_o    (dbus_addr_o),
    .dbus_wdata_o   (dbus_wdata_o),
    .dbus_be_o      (dbus_be_o),
    .dbus_ack_i     (ack),
    .dbus_rdata_i   (rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_done = 1'b0, exp_mis = 1'b0, exp_req = 1'b0, exp_we = 1'b0;
  logic        exp_pay = 1'b0, exp_pay_st = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_load = '0;
  logic [3:0]  exp_be = '0;

  int          stall_cnt, req_cnt, done_cyc, done_cnt, mis_cnt;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_stable;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference behaviour in plain arithmetic terms.
  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
    int off = int'(addr % 4);
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic [31:0] addr,
                                             input logic uns, input logic [31:0] rd);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (rd >> (8 * (addr % 4))) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = (rd >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic model_mis(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("stall", 32'(stall_o), 32'(exp_stall));
      checkOutput("done", 32'(done_o), 32'(exp_done));
      checkOutput("misalign", 32'(misalign_o), 32'(exp_mis));
      checkOutput("dbus_req", 32'(dbus_req_o), 32'(exp_req));
      checkOutput("load_data", load_data_o, exp_load);
      if (exp_pay) begin
        checkOutput("dbus_we", 32'(dbus_we_o), 32'(exp_we));
        checkOutput("dbus_addr", dbus_addr_o, exp_addr);
      end
      if (exp_pay_st) begin
        checkOutput("dbus_be", 32'(dbus_be_o), 32'(exp_be));
        checkOutput("dbus_wdata", dbus_wdata_o, exp_wdata);
      end
    end
  end

  task automatic sampleCycle(input int c);
    if (stall_o) stall_cnt++;
    if (done_o) begin done_cyc = c; done_cnt++; end
    if (misalign_o) mis_cnt++;
    if (dbus_req_o) begin
      if (req_cnt == 0) begin
        cap_addr = dbus_addr_o; cap_be = dbus_be_o; cap_wdata = dbus_wdata_o;
      end else if (cap_addr !== dbus_addr_o || cap_be !== dbus_be_o || cap_wdata !== dbus_wdata_o) begin
        cap_stable = 1'b0;
      end
      req_cnt++;
    end
  endtask

  // Cycle 0 accepts; ack in cycle k; a misaligned access behaves as k = 0 without bus.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [31:0] rd, input int k);
    logic mis;
    int   kk;
    mis = model_mis(size, addr);
    kk  = mis ? 0 : k;
    stall_cnt = 0; req_cnt = 0; done_cyc = -1; done_cnt = 0; mis_cnt = 0; cap_stable = 1'b1;
    for (int c = 0; c <= kk + 1; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        mem_req = 1'b1; mem_we = we; mem_size = size; mem_uns = uns; alu = addr; rd2 = data;
      end
      ack   = (!mis && c == kk);
      rdata = (!mis && c == kk) ? rd : 32'h5A5A_5A5A;
      exp_stall = (c <= kk);
      exp_req   = !mis && c >= 1 && c <= kk;
      exp_done  = (c == kk + 1);
      exp_mis   = exp_done && mis;
      if (c == 1 && !mis) begin
        exp_we = we; exp_addr = addr & ~32'd3;
        exp_be = model_be(size, addr); exp_wdata = model_wdata(size, data);
      end
      exp_pay    = exp_req;
      exp_pay_st = exp_req && we;
      if (c == kk + 1 && !mis && !we) exp_load = model_load(size, addr, uns, rd);
      #5;
      sampleCycle(c);
    end
    @(posedge clk); #1;
    mem_req = 1'b0; ack = 1'b1; rdata = 32'hFFFF_FFFF;
    exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_mis = 1'b0;
    exp_pay = 1'b0; exp_pay_st = 1'b0;
    #5;
    sampleCycle(kk + 2);
  endtask

  task automatic resetMidBusy();
    stall_cnt = 0; req_cnt = 0; done_cyc = -1; done_cnt = 0; mis_cnt = 0; cap_stable = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      ack = 1'b0;
      if (c == 0) begin
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_uns = 1'b0;
        alu = 32'h0000_0600; rd2 = 32'h0;
      end
      if (c == 2) begin rst = 1'b1; mem_req = 1'b0; end
      if (c == 3) begin rst = 1'b0; ack = 1'b1; rdata = 32'h1111_1111; end
      exp_stall = (c <= 2);
      exp_req   = (c == 1 || c == 2);
      exp_done  = 1'b0;
      exp_mis   = 1'b0;
      exp_we    = 1'b0;
      exp_addr  = (c <= 2) ? 32'h0000_0600 : 32'h0;
      exp_pay   = (c >= 1);
      exp_pay_st = (c >= 3);
      exp_be    = 4'h0;
      exp_wdata = 32'h0;
      if (c >= 3) exp_load = 32'h0;
      #5;
      sampleCycle(c);
    end
    ack = 1'b0;
    exp_pay = 1'b0; exp_pay_st = 1'b0;
  endtask

  initial begin
    $display("[TB] lsu bench start");
    @(posedge clk); #1;
    exp_load = 32'h0; exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0; exp_we = 1'b0;
    exp_pay = 1'b1; exp_pay_st = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #5;
    checkOutput("reset_load", load_data_o, 32'h0);
    checkOutput("reset_be", 32'(dbus_be_o), 32'h0);
    exp_pay = 1'b0; exp_pay_st = 1'b0;

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1);
    checkOutput("sw_be", 32'(cap_be), 32'hF);
    checkOutput("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
    checkOutput("sw_addr", cap_addr, 32'h0000_0100);
    checkOutput("sw_done_cycle", 32'(done_cyc), 32'd2);
    checkOutput("sw_stall_cycles", 32'(stall_cnt), 32'd2);

    applyStimulus(1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00A5, 32'h0, 1);
    checkOutput("sb_be", 32'(cap_be), 32'h8);
    checkOutput("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    checkOutput("sb_addr", cap_addr, 32'h0000_0100);

    applyStimulus(1'b0, 2'd0, 1'b0, 32'h0000_0202, 32'h0, 32'h12F0_3456, 1);
    checkOutput("lb_signed", load_data_o, 32'hFFFF_FFF0);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h0000_0202, 32'h0, 32'h12F0_3456, 2);
    checkOutput("lbu", load_data_o, 32'h0000_00F0);

    applyStimulus(1'b0, 2'd1, 1'b0, 32'h0000_0302, 32'h0, 32'h8001_0000, 3);
    checkOutput("lh_req_cycles", 32'(req_cnt), 32'd3);
    checkOutput("lh_payload_stable", 32'(cap_stable), 32'd1);
    checkOutput("lh_stall_cycles", 32'(stall_cnt), 32'd4);
    checkOutput("lh_load", load_data_o, 32'hFFFF_8001);

    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0401, 32'h0, 32'hCAFE_CAFE, 1);
    checkOutput("lw_mis_done_cycle", 32'(done_cyc), 32'd1);
    checkOutput("lw_mis_flag", 32'(mis_cnt), 32'd1);
    checkOutput("lw_mis_req", 32'(req_cnt), 32'd0);
    checkOutput("lw_mis_load_kept", load_data_o, 32'hFFFF_8001);

    applyStimulus(1'b1, 2'd1, 1'b0, 32'h0000_0106, 32'h1234_ABCD, 32'h0, 2);
    checkOutput("sh_be", 32'(cap_be), 32'hC);
    checkOutput("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h0000_0300, 32'h0, 32'h8001_7FFE, 1);
    checkOutput("lhu_lo", load_data_o, 32'h0000_7FFE);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, 4);
    checkOutput("lw", load_data_o, 32'hCAFE_F00D);
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h0000_0201, 32'h5555_5555, 32'h0, 1);
    checkOutput("sh_mis_req", 32'(req_cnt), 32'd0);
    applyStimulus(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 1);
    checkOutput("size11_mis", 32'(mis_cnt), 32'd1);
    checkOutput("size11_load_kept", load_data_o, 32'hCAFE_F00D);

    resetMidBusy();
    checkOutput("rst_done_count", 32'(done_cnt), 32'd0);
    checkOutput("rst_load", load_data_o, 32'h0);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
